// File: rtl/aes_ctr_pkg.sv
// Shared types and widths for the AES-CTR sequencer.
package aes_ctr_pkg;

    localparam int BLOCK_W = 128;
    localparam int NONCE_W = 96;
    localparam int CTR_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        GEN    = 2'd2,
        KS_RDY = 2'd3
    } state_e;

endpackage

// File: rtl/aes_ctr_outbuf.sv
// Single-entry valid/ready output register. A load and a drain may occur on
// the same edge; the load wins and the entry stays valid.
module aes_ctr_outbuf
    import aes_ctr_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] load_data_i,
    input  logic               ready_i,
    output logic               can_load_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               valid_o
);

    logic [BLOCK_W-1:0] data_q;
    logic               valid_q;

    // Room for a new entry when empty or when the current entry leaves this cycle.
    assign can_load_o = !valid_q || ready_i;
    assign data_o     = data_q;
    assign valid_o    = valid_q;

    // Entry register: load has priority over drain; data is held after drain.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= load_data_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer sitting between the payload stream and an AES-256 core.
// Builds {nonce, ctr} counter blocks, captures the returned keystream and
// XORs it onto one payload block per keystream block.
//
// state  | meaning
// IDLE   | nothing in flight; waiting for start_i (also terminal after wrap)
// PREP   | one cycle with core_en_o low so the core restarts its rounds
// GEN    | core enabled on a stable counter block; waiting for core_done_i
// KS_RDY | keystream held in ks_q; waiting to accept one payload block
module aes_ctr_sequencer
    import aes_ctr_pkg::*;
#(
    parameter int NONCE_W = aes_ctr_pkg::NONCE_W,
    parameter int CTR_W   = aes_ctr_pkg::CTR_W
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [NONCE_W-1:0] nonce_i,
    input  logic [CTR_W-1:0]   ctr_init_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               data_valid_i,
    output logic               data_ready_o,
    output logic [BLOCK_W-1:0] data_o,
    output logic               data_valid_o,
    input  logic               data_ready_i,
    output logic               core_en_o,
    output logic [BLOCK_W-1:0] core_block_o,
    input  logic [BLOCK_W-1:0] core_block_i,
    input  logic               core_done_i,
    input  logic               core_busy_i,
    output logic               ctr_wrap_o
);

    state_e             state_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [CTR_W-1:0]   ctr_q;
    logic [BLOCK_W-1:0] ks_q;
    logic               core_en_q;
    logic               wrap_q;
    logic               buf_can_load;
    logic               accept;
    logic               unused_busy;

    // Core busy is informational only; sequencing relies on core_done_i.
    assign unused_busy = core_busy_i;

    // start_i takes priority over a payload accept in the same cycle.
    assign data_ready_o = (state_q == KS_RDY) && buf_can_load && !start_i;
    assign accept       = data_valid_i && data_ready_o;

    assign core_en_o    = core_en_q;
    assign core_block_o = {nonce_q, ctr_q};
    assign ctr_wrap_o   = wrap_q;

    // Sequencer FSM with counter, keystream capture and registered core enable.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            nonce_q   <= '0;
            ctr_q     <= '0;
            ks_q      <= '0;
            core_en_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else if (start_i) begin
            // Any in-flight keystream is dropped; the output buffer is untouched.
            state_q   <= PREP;
            nonce_q   <= nonce_i;
            ctr_q     <= ctr_init_i;
            ks_q      <= '0;
            core_en_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    core_en_q <= 1'b0;
                end
                PREP: begin
                    state_q   <= GEN;
                    core_en_q <= 1'b1;
                end
                GEN: begin
                    if (core_done_i) begin
                        ks_q      <= core_block_i;
                        state_q   <= KS_RDY;
                        core_en_q <= 1'b0;
                    end
                end
                KS_RDY: begin
                    if (accept) begin
                        if (ctr_q != '1) begin
                            ctr_q   <= ctr_q + CTR_W'(1);
                            state_q <= PREP;
                        end else begin
                            // Counter space exhausted: never reuse a keystream block.
                            wrap_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    core_en_q <= 1'b0;
                end
            endcase
        end
    end

    aes_ctr_outbuf u_outbuf (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i (data_i ^ ks_q),
        .ready_i     (data_ready_i),
        .can_load_o  (buf_can_load),
        .data_o      (data_o),
        .valid_o     (data_valid_o)
    );

endmodule
